// File: rtl/rot_pkg.sv
// Shared types and default constants for the rotary parameter scheduler.
package rot_pkg;

  localparam int                 WIDTH        = 15;
  localparam logic [WIDTH-1:0]   DEFAULT_VAL  = 15'h2000;
  localparam int                 FINE_SHIFT   = 2;
  localparam int                 COARSE_SHIFT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } upd_state_t;

endpackage

// File: rtl/rot_param_sched_if.sv
// Update-record channel from the scheduler to its consumer.
interface rot_param_sched_if
  import rot_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int VAL_W = 15
) ();

  // A record moves when upd_valid and upd_ready are both high on a rising edge;
  // once upd_valid rises, upd_idx/upd_value hold until that edge.
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic [VAL_W-1:0] upd_value;

  modport master (output upd_valid, output upd_idx, output upd_value, input upd_ready);
  modport slave  (input upd_valid, input upd_idx, input upd_value, output upd_ready);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; pulses one cycle on each accepted rising edge.
module btn_debounce
  import rot_pkg::*;
#(
  parameter int CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        stable <= sync2;
        rise   <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rot_param_sched.sv
// One rotary encoder edits NPARAM saturating registers; changed values are queued as update records.
module rot_param_sched #(
  parameter int                NPARAM          = 8,
  parameter int                WIDTH           = rot_pkg::WIDTH,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL     = rot_pkg::DEFAULT_VAL,
  parameter int                FINE_SHIFT      = rot_pkg::FINE_SHIFT,
  parameter int                COARSE_SHIFT    = rot_pkg::COARSE_SHIFT,
  parameter int                DEBOUNCE_CYCLES = 65536
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rot_event,
  input  logic                      rot_left,
  input  logic                      cfg,
  input  logic                      btn_coarse,
  input  logic                      btn_sel,
  output logic [$clog2(NPARAM)-1:0] sel_idx,
  output logic [WIDTH-1:0]          sel_value,
  output rot_pkg::upd_state_t       upd_state,
  rot_param_sched_if.master         upd
);

  localparam int              IW    = $clog2(NPARAM);
  localparam logic [WIDTH:0]  MAX_V = {1'b0, {WIDTH{1'b1}}};

  rot_pkg::upd_state_t state, state_next;

  logic [WIDTH-1:0]  regs      [NPARAM];
  logic [WIDTH-1:0]  regs_next [NPARAM];
  logic [NPARAM-1:0] pending, pend_set, pend_clr;
  logic              sel_adv;
  logic [IW-1:0]     sel_nxt;
  logic [WIDTH:0]    step, cur, sum;
  logic [WIDTH-1:0]  new_val;
  logic              dec;
  logic [IW-1:0]     low_idx;
  logic              capture;
  logic [IW-1:0]     upd_idx_q;
  logic [WIDTH-1:0]  upd_value_q;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_sel),
    .rise  (sel_adv)
  );

  // Saturating step on the currently selected register; sel_idx is the pre-advance index.
  always_comb begin
    step     = {{WIDTH{1'b0}}, 1'b1} << (btn_coarse ? COARSE_SHIFT : FINE_SHIFT);
    cur      = {1'b0, regs[sel_idx]};
    sum      = cur + step;
    dec      = (rot_left == cfg);
    new_val  = regs[sel_idx];
    pend_set = '0;
    for (int i = 0; i < NPARAM; i++) regs_next[i] = regs[i];
    if (rot_event) begin
      if (dec) new_val = (cur < step) ? '0 : WIDTH'(cur - step);
      else     new_val = (sum > MAX_V) ? MAX_V[WIDTH-1:0] : sum[WIDTH-1:0];
      if (new_val != regs[sel_idx]) begin
        regs_next[sel_idx] = new_val;
        pend_set[sel_idx]  = 1'b1;
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NPARAM - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IW'(i);
    end
  end

  assign sel_nxt = sel_idx + IW'(sel_adv);

  always_comb begin
    state_next = state;
    pend_clr   = '0;
    capture    = 1'b0;
    case (state)
      rot_pkg::IDLE: begin
        if (|pending) begin
          capture           = 1'b1;
          pend_clr[low_idx] = 1'b1;
          state_next        = rot_pkg::SEND;
        end
      end
      rot_pkg::SEND: begin
        if (upd.upd_ready) state_next = rot_pkg::IDLE;
      end
      default: state_next = rot_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= rot_pkg::IDLE;
      for (int i = 0; i < NPARAM; i++) regs[i] <= DEFAULT_VAL;
      pending     <= '1;
      sel_idx     <= '0;
      sel_value   <= DEFAULT_VAL;
      upd_idx_q   <= '0;
      upd_value_q <= '0;
    end else begin
      state <= state_next;
      for (int i = 0; i < NPARAM; i++) regs[i] <= regs_next[i];
      // Set ordered after clear so a fresh change re-queues a parameter being captured.
      pending   <= (pending & ~pend_clr) | pend_set;
      sel_idx   <= sel_nxt;
      sel_value <= regs_next[sel_nxt];
      if (capture) begin
        upd_idx_q   <= low_idx;
        upd_value_q <= regs[low_idx];
      end
    end
  end

  assign upd.upd_valid = (state == rot_pkg::SEND);
  assign upd.upd_idx   = upd_idx_q;
  assign upd.upd_value = upd_value_q;
  assign upd_state     = state;

endmodule

// File: tb/tb_rot_param_sched.sv
// Directed bench for rot_param_sched: reset broadcast, saturation, debounce, backpressure, select/rotate collision.
module tb_rot_param_sched;
  import rot_pkg::*;

  localparam int DEB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rot_event, rot_left, cfg, btn_coarse, btn_sel;
  logic [2:0]  sel_idx;
  logic [14:0] sel_value;
  upd_state_t  upd_state;

  rot_param_sched_if #(.IDX_W(3), .VAL_W(15)) upd_if ();

  rot_param_sched #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rot_event  (rot_event),
    .rot_left   (rot_left),
    .cfg        (cfg),
    .btn_coarse (btn_coarse),
    .btn_sel    (btn_sel),
    .sel_idx    (sel_idx),
    .sel_value  (sel_value),
    .upd_state  (upd_state),
    .upd        (upd_if)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [17:0] exp_q[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    if (!reset && upd_if.upd_valid && upd_if.upd_ready) begin
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_rec", {upd_if.upd_idx, upd_if.upd_value}, 18'h3ffff);
      else check("rec", {upd_if.upd_idx, upd_if.upd_value}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rot_ev(input logic left, input logic coarse);
    rot_event  = 1'b1;
    rot_left   = left;
    btn_coarse = coarse;
    step();
    rot_event  = 1'b0;
  endtask

  task automatic push_rec(input logic [2:0] idx, input logic [14:0] val);
    exp_q.push_back({idx, val});
  endtask

  task automatic drain();
    int t = 0;
    upd_if.upd_ready = 1'b1;
    while (exp_q.size() != 0 && t < 300) begin
      step();
      t++;
    end
    check("drain_done", exp_q.size(), 0);
    step();
    step();
    check("idle_after_drain", upd_if.upd_valid, 0);
  endtask

  task automatic release_btn();
    for (int i = 0; i < 10; i++) begin
      btn_sel = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
    end
    btn_sel = 1'b0;
    repeat (DEB + 8) step();
  endtask

  task automatic press(input logic [2:0] exp_idx, output int n);
    logic [2:0] old;
    for (int i = 0; i < 10; i++) begin
      btn_sel = (i % 2 == 0);
      step();
    end
    btn_sel = 1'b1;
    old = sel_idx;
    n = 0;
    while (sel_idx == old && n < 100) begin
      step();
      n++;
    end
    check("press_idx", sel_idx, exp_idx);
    repeat (2 * DEB) step();
    check("press_once", sel_idx, exp_idx);
    release_btn();
  endtask

  int lat;
  int dummy;

  initial begin
    reset = 1'b1; rot_event = 1'b0; rot_left = 1'b0; cfg = 1'b1;
    btn_coarse = 1'b0; btn_sel = 1'b0; upd_if.upd_ready = 1'b1;
    repeat (3) step();
    check("rst_sel_idx", sel_idx, 0);
    check("rst_sel_value", sel_value, 15'h2000);
    check("rst_valid", upd_if.upd_valid, 0);
    check("rst_upd_idx", upd_if.upd_idx, 0);
    check("rst_upd_value", upd_if.upd_value, 0);
    check("rst_state", upd_state, IDLE);

    // reset broadcast, one record per two cycles
    acc_cyc.delete();
    for (int i = 0; i < 8; i++) push_rec(3'(i), 15'h2000);
    reset = 1'b0;
    drain();
    check("bcast_count", acc_cyc.size(), 8);
    if (acc_cyc.size() >= 8) check("bcast_spacing", acc_cyc[7] - acc_cyc[0], 14);

    // reset during SEND, then three fine increments on idx 0
    upd_if.upd_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("send_valid", upd_if.upd_valid, 1);
    check("send_value", upd_if.upd_value, 15'h2000);
    reset = 1'b1;
    step();
    check("rst_in_send_valid", upd_if.upd_valid, 0);
    check("rst_in_send_value", upd_if.upd_value, 0);
    reset = 1'b0;
    cfg = 1'b1;
    rot_ev(1'b0, 1'b0);
    check("inc_latency", sel_value, 15'h2004);
    rot_ev(1'b0, 1'b0);
    rot_ev(1'b0, 1'b0);
    check("inc_three", sel_value, 15'h200C);
    check("inflight_idx", upd_if.upd_idx, 0);
    check("inflight_value", upd_if.upd_value, 15'h2000);
    push_rec(3'd0, 15'h2000);
    push_rec(3'd0, 15'h200C);
    for (int i = 1; i < 8; i++) push_rec(3'(i), 15'h2000);
    drain();

    // lower saturation with the counter-clockwise polarity
    upd_if.upd_ready = 1'b0;
    cfg = 1'b0;
    for (int i = 0; i < 33; i++) rot_ev(1'b0, 1'b1);
    check("sat_low", sel_value, 15'h0000);
    check("sat_low_inflight", upd_if.upd_value, 15'h1F0C);
    push_rec(3'd0, 15'h1F0C);
    push_rec(3'd0, 15'h0000);
    drain();
    rot_ev(1'b0, 1'b1);
    repeat (10) step();
    check("sat_low_hold", sel_value, 15'h0000);
    check("sat_low_norec", upd_if.upd_valid, 0);

    // upper saturation: 0x7FF0 + coarse clips to 0x7FFF
    upd_if.upd_ready = 1'b0;
    cfg = 1'b1;
    for (int i = 0; i < 127; i++) rot_ev(1'b0, 1'b1);
    for (int i = 0; i < 60; i++) rot_ev(1'b0, 1'b0);
    check("reach_7ff0", sel_value, 15'h7FF0);
    rot_ev(1'b0, 1'b1);
    check("sat_high", sel_value, 15'h7FFF);
    check("sat_high_inflight", upd_if.upd_value, 15'h0100);
    push_rec(3'd0, 15'h0100);
    push_rec(3'd0, 15'h7FFF);
    drain();
    rot_ev(1'b0, 1'b1);
    repeat (10) step();
    check("sat_high_hold", sel_value, 15'h7FFF);
    check("sat_high_norec", upd_if.upd_valid, 0);

    // debounced select, eight presses wrap
    press(3'd1, lat);
    check("deb_latency_ok", (lat >= DEB && lat <= DEB + 4), 1);
    check("sel_value_idx1", sel_value, 15'h2000);
    for (int i = 2; i <= 8; i++) press(3'(i % 8), dummy);
    check("wrap_value_idx0", sel_value, 15'h7FFF);

    // backpressure on idx 2
    press(3'd1, dummy);
    press(3'd2, dummy);
    upd_if.upd_ready = 1'b0;
    rot_ev(1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) rot_ev(1'b0, 1'b0);
      else step();
      if (i == 10) check("bp_mid_value", upd_if.upd_value, 15'h2004);
    end
    check("bp_valid", upd_if.upd_valid, 1);
    check("bp_idx", upd_if.upd_idx, 2);
    check("bp_end_value", upd_if.upd_value, 15'h2004);
    check("bp_sel_value", sel_value, 15'h2008);
    push_rec(3'd2, 15'h2004);
    push_rec(3'd2, 15'h2008);
    drain();

    // rotate on the same edge as the select advance from idx 3
    press(3'd3, dummy);
    upd_if.upd_ready = 1'b0;
    btn_sel = 1'b1;
    repeat (lat - 1) step();
    rot_event = 1'b1; rot_left = 1'b0; btn_coarse = 1'b0;
    step();
    rot_event = 1'b0;
    check("coll_sel_idx", sel_idx, 4);
    check("coll_idx4_value", sel_value, 15'h2000);
    step();
    check("coll_rec_idx", upd_if.upd_idx, 3);
    check("coll_rec_value", upd_if.upd_value, 15'h2004);
    push_rec(3'd3, 15'h2004);
    repeat (2 * DEB) step();
    release_btn();
    check("coll_sel_hold", sel_idx, 4);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
